// File: rtl/lfsr_arbiter.sv
// Round-robin arbiter that hands each granted requester one word from a 16-bit LFSR.
// The LFSR warms up for WARMUP steps after every reset or reseed before serving.
module lfsr_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          WARMUP   = 8,
  parameter logic [15:0] ZERO_SUB = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        seed,
  input  logic               seed_load,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rnd_valid,
  output logic [15:0]        rnd_data,
  output logic               busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_SERVE  = 1'b1
  } state_t;

  localparam state_t INIT_STATE = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

  state_t             state_reg, state_next;
  logic [7:0]         warm_reg, warm_next;
  logic [15:0]        lfsr_reg, lfsr_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic [NUM_REQ-1:0] gnt_next;
  logic               valid_next;
  logic [15:0]        data_next;
  logic [15:0]        lfsr_step;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [NUM_REQ-1:0] onehot;

  assign lfsr_step = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[14]};
  assign busy      = (state_reg != ST_SERVE);

  // Search starts one past the previous winner and wraps, so the first hit is fairest.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = last_reg;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = int'(last_reg) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[IDX_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign onehot[gi] = found && (winner == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    warm_next  = warm_reg;
    lfsr_next  = lfsr_reg;
    last_next  = last_reg;
    gnt_next   = '0;
    valid_next = 1'b0;
    data_next  = rnd_data;
    // A reseed preempts everything, including a grant that would otherwise issue now.
    if (seed_load) begin
      lfsr_next  = (seed == 16'h0000) ? ZERO_SUB : seed;
      warm_next  = 8'd0;
      state_next = INIT_STATE;
    end else begin
      case (state_reg)
        ST_WARMUP: begin
          lfsr_next = lfsr_step;
          warm_next = warm_reg + 8'd1;
          if (warm_reg == WARM_LAST) state_next = ST_SERVE;
        end
        ST_SERVE: begin
          if (found) begin
            gnt_next   = onehot;
            valid_next = 1'b1;
            data_next  = lfsr_reg;
            lfsr_next  = lfsr_step;
            last_next  = winner;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= INIT_STATE;
      warm_reg  <= 8'd0;
      lfsr_reg  <= ZERO_SUB;
      last_reg  <= LAST_INIT;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= 16'h0000;
    end else begin
      state_reg <= state_next;
      warm_reg  <= warm_next;
      lfsr_reg  <= lfsr_next;
      last_reg  <= last_next;
      gnt       <= gnt_next;
      rnd_valid <= valid_next;
      rnd_data  <= data_next;
    end
  end

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Directed bench: a 4-requester arbiter with WARMUP=2 and a 3-requester one with WARMUP=0.
module tb_lfsr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] seed_a, seed_b;
  logic        load_a, load_b;
  logic [3:0]  req_a;
  logic [2:0]  req_b;
  logic [3:0]  gnt_a;
  logic [2:0]  gnt_b;
  logic        valid_a, valid_b, busy_a, busy_b;
  logic [15:0] data_a, data_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] m;

  logic [3:0]  rot_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [15:0] w2_data [3] = '{16'h0004, 16'h0008, 16'h0010};
  logic [2:0]  b_gnt   [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  logic [15:0] b_data  [4] = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F};

  lfsr_arbiter #(.NUM_REQ(4), .WARMUP(2), .ZERO_SUB(16'hACE1)) dut_a (
    .clk(clk), .reset(reset), .seed(seed_a), .seed_load(load_a), .req(req_a),
    .gnt(gnt_a), .rnd_valid(valid_a), .rnd_data(data_a), .busy(busy_a)
  );

  lfsr_arbiter #(.NUM_REQ(3), .WARMUP(0), .ZERO_SUB(16'hACE1)) dut_b (
    .clk(clk), .reset(reset), .seed(seed_b), .seed_load(load_b), .req(req_b),
    .gnt(gnt_b), .rnd_valid(valid_b), .rnd_data(data_b), .busy(busy_b)
  );

  function automatic logic [15:0] nxt(input logic [15:0] x);
    return {x[14:0], x[15] ^ x[14]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_a = 4'b1111; req_b = 3'b000;
    load_a = 1'b0; load_b = 1'b0; seed_a = 16'h0; seed_b = 16'h0;
    #12;
    checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || data_a !== 16'h0000 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_a: gnt=%b valid=%b data=%h busy=%b, expected 0000 0 0000 1",
               gnt_a, valid_a, data_a, busy_a);
    end
    checks++;
    if (gnt_b !== 3'b000 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b: gnt=%b valid=%b busy=%b, expected 000 0 0", gnt_b, valid_b, busy_b);
    end
    tick;
    reset = 1'b0;
  endtask

  task automatic test_warmup_rotation;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL warm_busy0: busy=%b expected 1", busy_a); end
    tick;
    checks++;
    if (busy_a !== 1'b1 || gnt_a !== 4'b0000) begin
      errors++; $display("FAIL warm_busy1: busy=%b gnt=%b expected 1 0000", busy_a, gnt_a);
    end
    tick;
    checks++;
    if (busy_a !== 1'b0 || gnt_a !== 4'b0000) begin
      errors++; $display("FAIL warm_done: busy=%b gnt=%b expected 0 0000", busy_a, gnt_a);
    end
    m = 16'hB387;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++;
      if (gnt_a !== rot_gnt[i] || valid_a !== 1'b1 || data_a !== m) begin
        errors++;
        $display("FAIL rot[%0d]: gnt=%b valid=%b data=%h, expected %b 1 %h",
                 i, gnt_a, valid_a, data_a, rot_gnt[i], m);
      end
      m = nxt(m);
    end
  endtask

  task automatic test_rr_skip;
    req_a = 4'b0101;
    tick;
    checks++;
    if (gnt_a !== 4'b0100 || data_a !== m) begin
      errors++; $display("FAIL skip0: gnt=%b data=%h expected 0100 %h", gnt_a, data_a, m);
    end
    m = nxt(m);
    tick;
    checks++;
    if (gnt_a !== 4'b0001 || data_a !== m) begin
      errors++; $display("FAIL skip1: gnt=%b data=%h expected 0001 %h", gnt_a, data_a, m);
    end
    m = nxt(m);
    req_a = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (gnt_a !== 4'b0000 || valid_a !== 1'b0) begin
        errors++; $display("FAIL idle[%0d]: gnt=%b valid=%b expected 0000 0", i, gnt_a, valid_a);
      end
    end
    req_a = 4'b0010;
    tick;
    checks++;
    if (gnt_a !== 4'b0010 || valid_a !== 1'b1 || data_a !== m) begin
      errors++; $display("FAIL idle_hold: gnt=%b data=%h expected 0010 %h", gnt_a, data_a, m);
    end
    m = nxt(m);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (gnt_a !== 4'b0010 || valid_a !== 1'b1 || data_a !== m) begin
        errors++; $display("FAIL b2b[%0d]: gnt=%b data=%h expected 0010 %h", i, gnt_a, data_a, m);
      end
      m = nxt(m);
    end
  endtask

  task automatic test_seed_warmup;
    seed_a = 16'h0001; load_a = 1'b1; req_a = 4'b0001;
    tick;
    load_a = 1'b0;
    checks++;
    if (gnt_a !== 4'b0000 || busy_a !== 1'b1) begin
      errors++; $display("FAIL load_cycle: gnt=%b busy=%b expected 0000 1", gnt_a, busy_a);
    end
    tick;
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL load_busy2: busy=%b expected 1", busy_a); end
    tick;
    checks++;
    if (busy_a !== 1'b0 || gnt_a !== 4'b0000) begin
      errors++; $display("FAIL load_serve: busy=%b gnt=%b expected 0 0000", busy_a, gnt_a);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if (gnt_a !== 4'b0001 || data_a !== w2_data[i]) begin
        errors++;
        $display("FAIL seed1[%0d]: gnt=%b data=%h expected 0001 %h", i, gnt_a, data_a, w2_data[i]);
      end
    end
  endtask

  task automatic test_seed_during_serve;
    req_a = 4'b1111;
    tick;
    checks++;
    if (gnt_a !== 4'b0010 || data_a !== 16'h0020) begin
      errors++; $display("FAIL pre_load: gnt=%b data=%h expected 0010 0020", gnt_a, data_a);
    end
    seed_a = 16'h8000; load_a = 1'b1;
    #1;
    checks++;
    if (gnt_a !== 4'b0010 || valid_a !== 1'b1 || data_a !== 16'h0020) begin
      errors++; $display("FAIL inflight: gnt=%b valid=%b data=%h expected 0010 1 0020",
                         gnt_a, valid_a, data_a);
    end
    tick;
    load_a = 1'b0;
    checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL reload_cycle: gnt=%b valid=%b busy=%b expected 0000 0 1",
                         gnt_a, valid_a, busy_a);
    end
    tick;
    tick;
    checks++;
    if (busy_a !== 1'b0 || gnt_a !== 4'b0000) begin
      errors++; $display("FAIL reload_serve: busy=%b gnt=%b expected 0 0000", busy_a, gnt_a);
    end
    tick;
    checks++;
    if (gnt_a !== 4'b0100 || data_a !== 16'h0002) begin
      errors++; $display("FAIL resume0: gnt=%b data=%h expected 0100 0002", gnt_a, data_a);
    end
    tick;
    checks++;
    if (gnt_a !== 4'b1000 || data_a !== 16'h0004) begin
      errors++; $display("FAIL resume1: gnt=%b data=%h expected 1000 0004", gnt_a, data_a);
    end
  endtask

  task automatic test_async_reset;
    tick;
    checks++;
    if (gnt_a !== 4'b0001 || data_a !== 16'h0008) begin
      errors++; $display("FAIL pre_reset: gnt=%b data=%h expected 0001 0008", gnt_a, data_a);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (gnt_a !== 4'b0000 || valid_a !== 1'b0 || data_a !== 16'h0000 || busy_a !== 1'b1) begin
      errors++; $display("FAIL async_reset: gnt=%b valid=%b data=%h busy=%b expected 0000 0 0000 1",
                         gnt_a, valid_a, data_a, busy_a);
    end
    tick;
    reset = 1'b0;
    tick;
    tick;
    tick;
    checks++;
    if (gnt_a !== 4'b0001 || valid_a !== 1'b1 || data_a !== 16'hB387) begin
      errors++; $display("FAIL post_reset: gnt=%b valid=%b data=%h expected 0001 1 b387",
                         gnt_a, valid_a, data_a);
    end
  endtask

  task automatic test_zero_seed;
    seed_b = 16'h0000; load_b = 1'b1; req_b = 3'b111;
    tick;
    load_b = 1'b0;
    checks++;
    if (gnt_b !== 3'b000 || valid_b !== 1'b0 || busy_b !== 1'b0) begin
      errors++; $display("FAIL zload: gnt=%b valid=%b busy=%b expected 000 0 0", gnt_b, valid_b, busy_b);
    end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (gnt_b !== b_gnt[i] || valid_b !== 1'b1 || data_b !== b_data[i]) begin
        errors++;
        $display("FAIL zseed[%0d]: gnt=%b valid=%b data=%h expected %b 1 %h",
                 i, gnt_b, valid_b, data_b, b_gnt[i], b_data[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_warmup_rotation;
    test_rr_skip;
    test_back_to_back;
    test_seed_warmup;
    test_seed_during_serve;
    test_async_reset;
    test_zero_seed;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
